sobel_edge_detect_3x3: RTL

Downstream consumer of `Matrix_Generate_3X3_8Bit` in the image pipeline.
- Takes the 3x3 grey-level window plus frame/line syncs and computes the Sobel gradient magnitude |Gx|+|Gy| through a 3-stage pipeline.
- Outputs a saturated 8-bit edge image and a thresholded 1-bit edge map, with syncs re-aligned to the data.
- Optionally reports the number of edge pixels in each frame, for autoexposure and scene-change logic.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_edge_detect_3x3_sync_delay_line.sv | 23 ++
 rtl/sobel_edge_detect_3x3.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, latency and arithmetic helpers for the Sobel edge detector.
package sobel_pkg;
    localparam int SOBEL_LATENCY = 3;
    localparam int SUM_W = 10;
    localparam int MAG_W = 11;
    localparam int CNT_W = 20;
    localparam logic [7:0] GRAY_MAX = 8'd255;

    function automatic logic [SUM_W-1:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/sobel_edge_detect_3x3_sync_delay_line.sv
// sync_delay_line: fixed-depth shift register that keeps the frame/line syncs aligned with the pipelined pixel data.
module sync_delay_line
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_LATENCY,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

    always_comb sr_d = {sr_q[DEPTH-2:0], din};

    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/sobel_edge_detect_3x3.sv
// sobel_edge_detect_3x3: 3-stage Sobel |Gx|+|Gy| with saturated gray and thresholded bit outputs.
// Define SOBEL_EDGE_COUNT_EN to build the per-frame edge pixel counter.
module sobel_edge_detect_3x3
    import sobel_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP      = 10'd640,
    parameter logic [9:0] IMG_VDISP      = 10'd480,
    parameter logic [7:0] THRESH_DEFAULT = 8'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_href,
    input  logic [7:0]       matrix_p11,
    input  logic [7:0]       matrix_p12,
    input  logic [7:0]       matrix_p13,
    input  logic [7:0]       matrix_p21,
    input  logic [7:0]       matrix_p22,
    input  logic [7:0]       matrix_p23,
    input  logic [7:0]       matrix_p31,
    input  logic [7:0]       matrix_p32,
    input  logic [7:0]       matrix_p33,
    input  logic [7:0]       edge_threshold,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic [7:0]       post_img_gray,
    output logic             post_img_bit,
    output logic [CNT_W-1:0] edge_count,
    output logic             edge_count_valid
);
    logic [SUM_W-1:0] lft_q, rgt_q, top_q, bot_q, lft_d, rgt_d, top_d, bot_d;
    logic [SUM_W-1:0] gx_q, gy_q, gx_d, gy_d;
    logic [MAG_W-1:0] mag;
    logic [7:0]       gray_q, gray_d, thr_q, thr_d;
    logic             bit_q, bit_d, vs_in_q, vs_in_d;
    logic [1:0]       sync_dly;

    if (32'(IMG_HDISP) * 32'(IMG_VDISP) > 32'((1 << CNT_W) - 1)) begin : g_cnt_range
        $error("edge counter too narrow for the configured frame size");
    end

    // matrix_p22 carries no Sobel weight and is intentionally left unused
    always_comb begin
        lft_d    = wsum(matrix_p11, matrix_p21, matrix_p31);
        rgt_d    = wsum(matrix_p13, matrix_p23, matrix_p33);
        top_d    = wsum(matrix_p11, matrix_p12, matrix_p13);
        bot_d    = wsum(matrix_p31, matrix_p32, matrix_p33);
        gx_d     = abs_diff(rgt_q, lft_q);
        gy_d     = abs_diff(bot_q, top_q);
        mag      = MAG_W'(gx_q) + MAG_W'(gy_q);
        gray_d   = (mag > MAG_W'(GRAY_MAX)) ? GRAY_MAX : mag[7:0];
        bit_d    = mag > MAG_W'(thr_q);
        vs_in_d  = matrix_frame_vsync;
        thr_d    = (matrix_frame_vsync && !vs_in_q) ? edge_threshold : thr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {lft_q, rgt_q, top_q, bot_q} <= '0;
            {gx_q, gy_q} <= '0;
            gray_q <= '0;
            bit_q <= 1'b0;
            vs_in_q <= 1'b0;
            thr_q <= THRESH_DEFAULT;
        end else begin
            {lft_q, rgt_q, top_q, bot_q} <= {lft_d, rgt_d, top_d, bot_d};
            {gx_q, gy_q} <= {gx_d, gy_d};
            gray_q <= gray_d;
            bit_q <= bit_d;
            vs_in_q <= vs_in_d;
            thr_q <= thr_d;
        end
    end

    sync_delay_line #(.DEPTH(SOBEL_LATENCY), .W(2)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({matrix_frame_vsync, matrix_frame_href}),
        .dout (sync_dly)
    );

    assign post_frame_vsync = sync_dly[1];
    assign post_frame_href  = sync_dly[0];
    assign post_img_gray    = post_frame_href ? gray_q : '0;
    assign post_img_bit     = post_frame_href & bit_q;

`ifdef SOBEL_EDGE_COUNT_EN
    // a post-side vsync rise only opens a frame once the delay line holds post-reset samples
    localparam logic [2:0] FLUSH_DONE = 3'(SOBEL_LATENCY + 1);
    logic [2:0]       flush_q, flush_d;
    logic             vs_out_q, vs_out_d, frame_active_q, frame_active_d, ecv_q, ecv_d;
    logic             vs_rise, vs_fall;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, edge_count_q, edge_count_d;

    always_comb begin
        vs_rise        = post_frame_vsync && !vs_out_q && (flush_q == FLUSH_DONE);
        vs_fall        = !post_frame_vsync && vs_out_q;
        cnt_inc        = cnt_q + CNT_W'(frame_active_q && post_img_bit && (cnt_q != '1));
        flush_d        = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 3'd1;
        vs_out_d       = post_frame_vsync;
        frame_active_d = vs_rise || (frame_active_q && !vs_fall);
        ecv_d          = vs_fall && frame_active_q;
        edge_count_d   = ecv_d ? cnt_inc : edge_count_q;
        cnt_d          = vs_fall ? '0 : cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_q <= '0;
            vs_out_q <= 1'b0;
            frame_active_q <= 1'b0;
            ecv_q <= 1'b0;
            cnt_q <= '0;
            edge_count_q <= '0;
        end else begin
            flush_q <= flush_d;
            vs_out_q <= vs_out_d;
            frame_active_q <= frame_active_d;
            ecv_q <= ecv_d;
            cnt_q <= cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count       = edge_count_q;
    assign edge_count_valid = ecv_q;
`else
    assign edge_count       = '0;
    assign edge_count_valid = 1'b0;
`endif
endmodule
